// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared CPU package: hazard-controller state encoding and pipeline depth constants.
package pipeline_hazard_ctrl_pkg;

    // Register-file address width (32 architectural registers)
    localparam int REG_ADDR_W = 5;

    // Edges needed for an instruction in ID to reach WB (ID->EX->MEM->WB)
    localparam int DRAIN_CYCLES_DEFAULT = 3;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_hdu.sv
// Load-use detector: a load in EX whose destination feeds a source read in ID.
module hazard_detect_unit
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs_id,
    input  logic [REG_ADDR_W-1:0] rt_id,
    input  logic                  use_rs_id,
    input  logic                  use_rt_id,
    input  logic [REG_ADDR_W-1:0] rd_ex,
    input  logic                  memread_ex,
    input  logic                  rwren_ex,
    output logic                  load_use
);

    logic rs_match;
    logic rt_match;

    // Register 0 is hardwired to zero, so a load targeting it never creates a dependency
    always_comb begin
        rs_match = use_rs_id & (rs_id == rd_ex);
        rt_match = use_rt_id & (rt_id == rd_ex);
        load_use = memread_ex & rwren_ex & (rd_ex != '0) & (rs_match | rt_match);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stalls, bubbles and halt drain for a 5-stage pipeline.
// Outputs are combinational so the stage registers see them before the same negedge.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
    parameter int CNT_W        = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [REG_ADDR_W-1:0] rs_id,
    input  logic [REG_ADDR_W-1:0] rt_id,
    input  logic                  use_rs_id,
    input  logic                  use_rt_id,
    input  logic [REG_ADDR_W-1:0] rd_ex,
    input  logic                  memread_ex,
    input  logic                  rwren_ex,
    input  logic                  redirect_mem,
    input  logic                  halt_id,
    input  logic                  mem_busy,
    output logic                  wen_pc,
    output logic                  wen_ifid,
    output logic                  wen_idex,
    output logic                  wen_exmem,
    output logic                  wen_memwb,
    output logic                  flush_ifid,
    output logic                  flush_idex,
    output logic                  flush_exmem,
    output logic                  halted,
    output logic [CNT_W-1:0]      stall_cnt
);

    // Drain counter only ever holds values up to DRAIN_CYCLES-1
    localparam int DCNT_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCNT_W-1:0] DRAIN_LOAD = DCNT_W'((DRAIN_CYCLES > 1) ? DRAIN_CYCLES - 1 : 0);

    hz_state_e          state_q, state_d;
    logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic load_use;
    logic hold_all;
    logic hold_front;
    logic fl_ifid, fl_idex, fl_exmem;
    logic any_act;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    hazard_detect_unit u_hdu (
        .rs_id      (rs_id),
        .rt_id      (rt_id),
        .use_rs_id  (use_rs_id),
        .use_rt_id  (use_rt_id),
        .rd_ex      (rd_ex),
        .memread_ex (memread_ex),
        .rwren_ex   (rwren_ex),
        .load_use   (load_use)
    );

    // Next-state and hold/flush decode; priority mem_busy > redirect > load-use > halt
    always_comb begin
        state_d    = state_q;
        dcnt_d     = dcnt_q;
        hold_all   = 1'b0;
        hold_front = 1'b0;
        fl_ifid    = 1'b0;
        fl_idex    = 1'b0;
        fl_exmem   = 1'b0;
        case (state_q)
            ST_HALTED: begin
                hold_all = 1'b1;
            end
            ST_DRAIN: begin
                if (mem_busy) begin
                    hold_all = 1'b1;
                end else if (redirect_mem) begin
                    // A redirect means the halt was on a squashed path: cancel it
                    fl_ifid  = 1'b1;
                    fl_idex  = 1'b1;
                    fl_exmem = 1'b1;
                    state_d  = ST_RUN;
                    dcnt_d   = '0;
                end else begin
                    // Halt is already past ID; keep bubbling behind it until it reaches WB
                    hold_front = 1'b1;
                    fl_idex    = 1'b1;
                    if (dcnt_q <= DCNT_W'(1)) begin
                        state_d = ST_HALTED;
                        dcnt_d  = '0;
                    end else begin
                        dcnt_d = dcnt_q - DCNT_W'(1);
                    end
                end
            end
            default: begin
                // RUN, and MEM_WAIT once memory is ready, share the same decode
                if (mem_busy) begin
                    hold_all = 1'b1;
                    state_d  = ST_MEM_WAIT;
                end else begin
                    state_d = ST_RUN;
                    if (redirect_mem) begin
                        fl_ifid  = 1'b1;
                        fl_idex  = 1'b1;
                        fl_exmem = 1'b1;
                    end else if (load_use) begin
                        hold_front = 1'b1;
                        fl_idex    = 1'b1;
                    end else if (halt_id) begin
                        hold_front = 1'b1;
                        if (DRAIN_CYCLES <= 1) begin
                            state_d = ST_HALTED;
                        end else begin
                            state_d = ST_DRAIN;
                            dcnt_d  = DRAIN_LOAD;
                        end
                    end
                end
            end
        endcase
    end

    // Outputs forced inactive while reset is held, regardless of the inputs
    always_comb begin
        wen_pc      = RST & (hold_all | hold_front);
        wen_ifid    = RST & (hold_all | hold_front);
        wen_idex    = RST & hold_all;
        wen_exmem   = RST & hold_all;
        wen_memwb   = RST & hold_all;
        flush_ifid  = RST & fl_ifid;
        flush_idex  = RST & fl_idex;
        flush_exmem = RST & fl_exmem;
        halted      = RST & (state_q == ST_HALTED);
        stall_cnt   = stall_cnt_q;
        any_act     = wen_pc | wen_ifid | wen_idex | wen_exmem | wen_memwb |
                      flush_ifid | flush_idex | flush_exmem;
        stall_cnt_d = any_act ? sat_inc(stall_cnt_q) : stall_cnt_q;
    end

    // State, drain counter and stall counter advance on the same negedge as the stage registers
    always_ff @(negedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_RUN;
            dcnt_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios followed by randomized traffic
// compared against a behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

    localparam int DRAIN = 3;
    localparam int CNT_W = 16;

    // Output vector order: {wen_pc, wen_ifid, wen_idex, wen_exmem, wen_memwb,
    //                       flush_ifid, flush_idex, flush_exmem, halted}
    localparam logic [8:0] V_IDLE   = 9'b00000_000_0;
    localparam logic [8:0] V_LU     = 9'b11000_010_0;
    localparam logic [8:0] V_HALTID = 9'b11000_000_0;
    localparam logic [8:0] V_DRAIN  = 9'b11000_010_0;
    localparam logic [8:0] V_FREEZE = 9'b11111_000_0;
    localparam logic [8:0] V_REDIR  = 9'b00000_111_0;
    localparam logic [8:0] V_HALTED = 9'b11111_000_1;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic [4:0]       rs_id = '0, rt_id = '0, rd_ex = '0;
    logic             use_rs_id = 0, use_rt_id = 0, memread_ex = 0, rwren_ex = 0;
    logic             redirect_mem = 0, halt_id = 0, mem_busy = 0;
    logic             wen_pc, wen_ifid, wen_idex, wen_exmem, wen_memwb;
    logic             flush_ifid, flush_idex, flush_exmem, halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [8:0]       dut_vec;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Behavioural model state
    bit m_halted = 0;
    int m_drain  = 0;   // edges still needed for an in-flight halt to reach WB
    int m_stall  = 0;

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST),
        .rs_id(rs_id), .rt_id(rt_id), .use_rs_id(use_rs_id), .use_rt_id(use_rt_id),
        .rd_ex(rd_ex), .memread_ex(memread_ex), .rwren_ex(rwren_ex),
        .redirect_mem(redirect_mem), .halt_id(halt_id), .mem_busy(mem_busy),
        .wen_pc(wen_pc), .wen_ifid(wen_ifid), .wen_idex(wen_idex),
        .wen_exmem(wen_exmem), .wen_memwb(wen_memwb),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    assign dut_vec = {wen_pc, wen_ifid, wen_idex, wen_exmem, wen_memwb,
                      flush_ifid, flush_idex, flush_exmem, halted};

    always #5 CLK = ~CLK;

    function automatic bit model_lu();
        return memread_ex && rwren_ex && (rd_ex != 0) &&
               ((use_rs_id && rs_id == rd_ex) || (use_rt_id && rt_id == rd_ex));
    endfunction

    function automatic logic [8:0] model_out();
        if (!RST)               return V_IDLE;
        if (m_halted)           return V_HALTED;
        if (mem_busy)           return V_FREEZE;
        if (redirect_mem)       return V_REDIR;
        if (m_drain > 0)        return V_DRAIN;
        if (model_lu())         return V_LU;
        if (halt_id)            return V_HALTID;
        return V_IDLE;
    endfunction

    task automatic model_edge();
        logic [8:0] o;
        o = model_out();
        if (!RST) return;
        if ((o[8:1] != 0) && (m_stall < (2**CNT_W) - 1)) m_stall++;
        if (m_halted || mem_busy) begin
            // frozen: nothing advances
        end else if (redirect_mem) begin
            m_drain = 0;
        end else if (m_drain > 0) begin
            m_drain--;
            if (m_drain == 0) m_halted = 1;
        end else if (!model_lu() && halt_id) begin
            m_drain = DRAIN - 1;
            if (m_drain == 0) m_halted = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs on posedge, then advance the model at the negedge
    task automatic step(input string tag, input bit use_const, input logic [8:0] exp_v, input int exp_cnt);
        @(posedge CLK);
        chk({tag, ".model_out"}, 32'(dut_vec), 32'(model_out()));
        chk({tag, ".model_cnt"}, 32'(stall_cnt), 32'(m_stall));
        if (use_const) begin
            chk({tag, ".out"}, 32'(dut_vec), 32'(exp_v));
            chk({tag, ".cnt"}, 32'(stall_cnt), 32'(exp_cnt));
        end
        @(negedge CLK);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rs_id = '0; rt_id = '0; rd_ex = '0;
        use_rs_id = 0; use_rt_id = 0; memread_ex = 0; rwren_ex = 0;
        redirect_mem = 0; halt_id = 0; mem_busy = 0;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        memread_ex = 1; rwren_ex = 1; rd_ex = rd; rs_id = 5'd5; use_rs_id = 1;
    endtask

    // Reset pulse started just after a negedge; outputs checked asynchronously
    task automatic do_reset(input string tag);
        RST = 1'b0;
        #1;
        chk({tag, ".rst_out"}, 32'(dut_vec), 32'(V_IDLE));
        chk({tag, ".rst_cnt"}, 32'(stall_cnt), 32'd0);
        m_halted = 0; m_drain = 0; m_stall = 0;
        @(negedge CLK);
        #1;
        RST = 1'b1;
    endtask

    initial begin
        int hc;
        idle();
        #2 RST = 1'b0;
        #2;
        chk("por.out", 32'(dut_vec), 32'(V_IDLE));
        chk("por.cnt", 32'(stall_cnt), 32'd0);
        @(negedge CLK);
        #1 RST = 1'b1;

        // Load-use: one stall cycle
        set_lu(5'd5);
        step("lu", 1, V_LU, 0);
        idle();
        step("lu_post", 1, V_IDLE, 1);

        // Load into r0 never stalls
        set_lu(5'd0);
        step("rd0", 1, V_IDLE, 1);
        idle();
        step("rd0_post", 1, V_IDLE, 1);

        // Redirect wins over load-use
        set_lu(5'd5);
        redirect_mem = 1;
        step("redir_lu", 1, V_REDIR, 1);
        idle();
        step("redir_post", 1, V_IDLE, 2);

        // Memory wait for four cycles
        do_reset("mw");
        mem_busy = 1;
        for (int i = 0; i < 4; i++) step("mw_busy", 1, V_FREEZE, i);
        mem_busy = 0;
        step("mw_run", 1, V_IDLE, 4);
        set_lu(5'd5);
        step("mw_lu", 1, V_LU, 4);
        idle();

        // Halt reaches WB after exactly DRAIN edges
        do_reset("halt");
        halt_id = 1;
        step("halt_id", 1, V_HALTID, 0);
        halt_id = 0;
        step("drain1", 1, V_DRAIN, 1);
        step("drain2", 1, V_DRAIN, 2);
        redirect_mem = 1;
        step("halted", 1, V_HALTED, 3);
        redirect_mem = 0;
        step("halted_hold", 1, V_HALTED, 4);

        // mem_busy mid-drain extends the drain by its length
        do_reset("hmb");
        halt_id = 1;
        step("hmb_id", 1, V_HALTID, 0);
        halt_id = 0;
        step("hmb_d1", 1, V_DRAIN, 1);
        mem_busy = 1;
        step("hmb_busy1", 1, V_FREEZE, 2);
        step("hmb_busy2", 1, V_FREEZE, 3);
        mem_busy = 0;
        step("hmb_d2", 1, V_DRAIN, 4);
        step("hmb_halted", 1, V_HALTED, 5);

        // Redirect in drain cancels the halt
        do_reset("hrd");
        halt_id = 1;
        step("hrd_id", 1, V_HALTID, 0);
        halt_id = 0;
        step("hrd_d1", 1, V_DRAIN, 1);
        redirect_mem = 1;
        step("hrd_redir", 1, V_REDIR, 2);
        redirect_mem = 0;
        step("hrd_run", 1, V_IDLE, 3);
        step("hrd_run2", 1, V_IDLE, 3);

        // Reset mid-drain takes effect before the next edge, even with mem_busy high
        do_reset("rmd");
        halt_id = 1;
        step("rmd_id", 1, V_HALTID, 0);
        halt_id = 0;
        mem_busy = 1;
        @(posedge CLK);
        #1 RST = 1'b0;
        #1;
        chk("rmd.async_out", 32'(dut_vec), 32'(V_IDLE));
        chk("rmd.async_cnt", 32'(stall_cnt), 32'd0);
        m_halted = 0; m_drain = 0; m_stall = 0;
        @(negedge CLK);
        #1 RST = 1'b1;
        mem_busy = 0;
        step("rmd_run", 1, V_IDLE, 0);

        // Randomized traffic against the model
        hc = 0;
        for (int n = 0; n < 400; n++) begin
            memread_ex   = 1'($urandom_range(0, 1));
            rwren_ex     = 1'($urandom_range(0, 1));
            rd_ex        = 5'($urandom_range(0, 3));
            rs_id        = 5'($urandom_range(0, 3));
            rt_id        = 5'($urandom_range(0, 3));
            use_rs_id    = 1'($urandom_range(0, 1));
            use_rt_id    = 1'($urandom_range(0, 1));
            mem_busy     = ($urandom_range(0, 4) == 0);
            redirect_mem = ($urandom_range(0, 7) == 0);
            halt_id      = ($urandom_range(0, 9) == 0);
            if (m_halted) hc++;
            if (hc > 2 || $urandom_range(0, 59) == 0) begin
                hc = 0;
                do_reset("rnd");
            end else begin
                step("rnd", 0, V_IDLE, 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL provide parameter DRAIN_CYCLES, default 3, meaning the number of edges needed for a halt in ID to reach WB.
REQ-002 The block SHALL provide parameter CNT_W, default 16, meaning the stall-counter width.
REQ-003 The block SHALL have port CLK, input, 1, pipeline clock; all state updates on negedge CLK, matching the stage registers.
REQ-004 The block SHALL have port RST, input, 1, reset; asynchronous, active-low.
REQ-005 The block SHALL have ports rs_id and rt_id, input, 5 each, source register numbers of the instruction in ID.
REQ-006 The block SHALL have ports use_rs_id and use_rt_id, input, 1 each, indicating that the ID instruction reads that source.
REQ-007 The block SHALL have ports rd_ex, input, 5, destination of EX; memread_ex, input, 1, EX is a load; rwren_ex, input, 1, EX writes the register file.
REQ-008 The block SHALL have ports redirect_mem, input, 1, taken branch or jump resolved in MEM; and halt_id, input, 1, halt decoded in ID.
REQ-009 The block SHALL have port mem_busy, input, 1, data memory not ready this cycle.
REQ-010 The block SHALL have outputs wen_pc, wen_ifid, wen_idex, wen_exmem and wen_memwb, 1 each, active-low: 0 = capture, 1 = hold.
REQ-011 The block SHALL have outputs flush_ifid, flush_idex and flush_exmem, 1 each, meaning load zeros into that stage register (a bubble) on this edge.
REQ-012 The block SHALL have outputs halted, 1, pipeline drained and frozen; and stall_cnt, CNT_W, saturating count of non-RUN or stalled cycles.

Function
REQ-013 The block SHALL implement states RUN, MEM_WAIT, DRAIN and HALTED.
REQ-014 load_use SHALL be memread_ex & rwren_ex & (rd_ex != 0) & ((use_rs_id & rs_id == rd_ex) | (use_rt_id & rt_id == rd_ex)).
REQ-015 In RUN, all wen outputs SHALL be 0 and all flushes 0 unless a condition below applies.
REQ-016 Priority SHALL be mem_busy > redirect_mem > load_use > halt_id.
REQ-017 On mem_busy in RUN or MEM_WAIT, all five wen outputs SHALL be 1 and no flush SHALL be asserted; the next state SHALL be MEM_WAIT.
REQ-018 The block SHALL return from MEM_WAIT to RUN on the first edge where mem_busy=0; that cycle SHALL be evaluated as RUN.
REQ-019 On redirect_mem without mem_busy, flush_ifid, flush_idex and flush_exmem SHALL be 1 for exactly that cycle and all wen SHALL be 0; load_use and halt_id SHALL be ignored in that cycle.
REQ-020 On load_use alone, wen_pc and wen_ifid SHALL be 1 and flush_idex SHALL be 1 for one cycle; EX/MEM and MEM/WB SHALL advance.
REQ-021 On halt_id alone in RUN, wen_pc and wen_ifid SHALL be 1, the drain counter SHALL load DRAIN_CYCLES-1, and the state SHALL become DRAIN.
REQ-022 In DRAIN, wen_pc and wen_ifid SHALL be 1, flush_idex SHALL be 1 after the halt leaves ID, and the counter SHALL decrement per edge.
REQ-023 DRAIN SHALL enter HALTED when the counter is 0 on an edge.
REQ-024 mem_busy in DRAIN SHALL freeze all stages and the counter.
REQ-025 redirect_mem in DRAIN SHALL flush per REQ-019 and return the state to RUN, cancelling the halt.
REQ-026 In HALTED, all wen outputs SHALL be 1, halted SHALL be 1, and the block SHALL exit only via RST.
REQ-027 stall_cnt SHALL increment on every edge where any wen is 1 or any flush is 1, and SHALL saturate at all-ones.
REQ-028 Outputs SHALL be combinational from the current state and inputs, with no registered latency, so the stage registers see them before the same negedge.

Reset
REQ-029 While RST=0, the state SHALL be RUN, the drain counter 0, stall_cnt 0, halted 0, all wen 0 and all flush 0.
REQ-030 Reset asserted mid-DRAIN or mid-MEM_WAIT SHALL abandon the operation immediately.

Structure
REQ-031 State encodings and DRAIN_CYCLES SHALL live in the shared CPU package.
REQ-032 The load-use comparator SHALL be a sub-module named hazard_detect_unit; the FSM, counter and output decode SHALL stay in the top module.

Verification
REQ-033 Load-use test: memread_ex=1, rwren_ex=1, rd_ex=5, rs_id=5, use_rs_id=1 -> one cycle with wen_pc=1, wen_ifid=1, flush_idex=1, stall_cnt=1.
REQ-034 rd_ex=0 test: apply the REQ-033 stimulus with rd_ex=0 -> no stall.
REQ-035 Redirect-over-load-use test: redirect_mem=1 together with load_use -> three flushes for one cycle, wen all 0.
REQ-036 Memory-wait test: mem_busy=1 for 4 cycles -> all wen=1 for 4 cycles, state RUN on the fifth, stall_cnt=4.
REQ-037 Halt test: halt_id=1 -> halted=1 after exactly 3 edges; then a mem_busy pulse mid-DRAIN extends this by its length.
REQ-038 Reset test: assert RST low during DRAIN -> all outputs return to their REQ-029 values asynchronously, before the next clock edge.
